// File: rtl/depacketizer_n.sv
// Flit-serial depacketizer: strips per-flit control/VC/dest fields and reassembles
// a 1..MAX_FLITS flit packet into one word held in a single-entry output register.
module depacketizer_n #(
   parameter  int WIDTH_FLIT       = 18,
   parameter  int MAX_FLITS        = 4,
   parameter  int WIDTH_DATA       = 48,
   parameter  int VC_ADDRESS_WIDTH = 1,
   parameter  int ADDRESS_WIDTH    = 4,
   localparam int HP  = WIDTH_FLIT - 3 - VC_ADDRESS_WIDTH - ADDRESS_WIDTH,
   localparam int BP  = WIDTH_FLIT - 3 - VC_ADDRESS_WIDTH,
   localparam int CAP = HP + (MAX_FLITS - 1) * BP,
   localparam int LW  = $clog2(MAX_FLITS + 1)
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [WIDTH_FLIT-1:0]       flit_in,
   input  logic                        valid_in,
   output logic                        ready_out,
   output logic [WIDTH_DATA-1:0]       data_out,
   output logic [VC_ADDRESS_WIDTH-1:0] vc_out,
   output logic [LW-1:0]               len_out,
   output logic                        valid_out,
   input  logic                        ready_in,
   output logic                        err_out
);

   typedef enum logic {IDLE, BODY} state_t;

   localparam logic SINGLE = (MAX_FLITS == 1);

   state_t                      state;
   logic [LW-1:0]               cnt;
   logic [LW-1:0]               cnt_inc;
   logic [CAP-1:0]              asm_r;
   logic [CAP-1:0]              asm_head;
   logic [CAP-1:0]              asm_body;
   logic [VC_ADDRESS_WIDTH-1:0] vc_r;
   logic [VC_ADDRESS_WIDTH-1:0] vc_in;
   logic                        accept;
   logic                        fv;
   logic                        hd;
   logic                        tl;
   int unsigned                 body_shift;

   assign ready_out = !valid_out || ready_in;
   assign accept    = valid_in && ready_out;
   assign fv        = flit_in[WIDTH_FLIT-1];
   assign hd        = flit_in[WIDTH_FLIT-2];
   assign tl        = flit_in[WIDTH_FLIT-3];
   assign vc_in     = flit_in[WIDTH_FLIT-4 -: VC_ADDRESS_WIDTH];
   assign cnt_inc   = cnt + LW'(1);

   // Body flit k lands BP bits below flit k-1; k equals the current count.
   always_comb begin
      body_shift = 0;
      if (int'(cnt) >= 1 && int'(cnt) < MAX_FLITS)
         body_shift = int'(CAP - HP - int'(cnt) * BP);
      asm_head = CAP'(flit_in[HP-1:0]) << (CAP - HP);
      asm_body = asm_r | (CAP'(flit_in[BP-1:0]) << body_shift);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         asm_r     <= '0;
         vc_r      <= '0;
         data_out  <= '0;
         vc_out    <= '0;
         len_out   <= '0;
         valid_out <= 1'b0;
         err_out   <= 1'b0;
      end else begin
         err_out <= 1'b0;
         if (ready_in)
            valid_out <= 1'b0;
         if (accept && fv) begin
            if (!hd) begin
               if (state == BODY) begin
                  asm_r <= asm_body;
                  cnt   <= cnt_inc;
                  if (tl || cnt_inc == LW'(MAX_FLITS)) begin
                     data_out  <= asm_body[CAP-1 -: WIDTH_DATA];
                     vc_out    <= vc_r;
                     len_out   <= cnt_inc;
                     valid_out <= 1'b1;
                     err_out   <= !tl;
                     state     <= IDLE;
                  end
               end else begin
                  err_out <= 1'b1;
               end
            end else begin
               // A head arriving in BODY abandons the partial packet, then starts afresh.
               err_out <= (state == BODY) || (SINGLE && !tl);
               asm_r   <= asm_head;
               vc_r    <= vc_in;
               cnt     <= LW'(1);
               if (tl || SINGLE) begin
                  data_out  <= asm_head[CAP-1 -: WIDTH_DATA];
                  vc_out    <= vc_in;
                  len_out   <= LW'(1);
                  valid_out <= 1'b1;
                  state     <= IDLE;
               end else begin
                  state <= BODY;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_depacketizer_n.sv
// Directed self-checking bench for depacketizer_n with default parameters
// (HP=10, BP=14, CAP=52, W=48).
module tb_depacketizer_n;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [17:0] flit_in;
   logic        valid_in;
   logic        ready_out;
   logic [47:0] data_out;
   logic [0:0]  vc_out;
   logic [2:0]  len_out;
   logic        valid_out;
   logic        ready_in;
   logic        err_out;

   int n_checks = 0;
   int n_errors = 0;
   int err_cnt  = 0;

   typedef struct {
      logic [47:0] d;
      logic [0:0]  v;
      logic [2:0]  l;
   } out_t;
   out_t out_q[$];

   depacketizer_n #(
      .WIDTH_FLIT(18),
      .MAX_FLITS(4),
      .WIDTH_DATA(48),
      .VC_ADDRESS_WIDTH(1),
      .ADDRESS_WIDTH(4)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .flit_in(flit_in),
      .valid_in(valid_in),
      .ready_out(ready_out),
      .data_out(data_out),
      .vc_out(vc_out),
      .len_out(len_out),
      .valid_out(valid_out),
      .ready_in(ready_in),
      .err_out(err_out)
   );

   always #5 clk = ~clk;

   // Inputs only change at posedge+2, so negedge sees stable pre-edge values.
   always @(negedge clk) begin
      if (err_out) err_cnt++;
      if (rst_n && valid_out && ready_in)
         out_q.push_back('{data_out, vc_out, len_out});
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not reach the end");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic put(input logic [17:0] f);
      int   n   = 0;
      logic acc = 1'b0;
      flit_in  = f;
      valid_in = 1'b1;
      while (!acc && n < 50) begin
         @(negedge clk);
         acc = ready_out;
         @(posedge clk);
         #2;
         n++;
      end
      valid_in = 1'b0;
      if (!acc) check("put_timeout", 64'(acc), 64'(1));
   endtask

   function automatic logic [17:0] head_f(input logic vc, input logic [9:0] pl, input logic tl);
      return {1'b1, 1'b1, tl, vc, 4'hA, pl};
   endfunction

   function automatic logic [17:0] body_f(input logic [13:0] pl, input logic tl);
      return {1'b1, 1'b0, tl, 1'b1, pl};
   endfunction

   logic [51:0] full;
   logic [47:0] word_a;
   logic [47:0] word_b;
   int          e0;

   initial begin
      rst_n    = 1'b0;
      valid_in = 1'b0;
      ready_in = 1'b1;
      flit_in  = '0;
      repeat (3) @(posedge clk);
      #2;
      check("rst_ready", 64'(ready_out), 64'(1));
      check("rst_valid", 64'(valid_out), 64'(0));
      check("rst_err",   64'(err_out),   64'(0));
      check("rst_data",  64'(data_out),  64'(0));
      check("rst_vc",    64'(vc_out),    64'(0));
      check("rst_len",   64'(len_out),   64'(0));
      rst_n = 1'b1;
      tick();

      // 4-flit packet
      e0 = err_cnt;
      put(head_f(1'b1, 10'h3FF, 1'b0));
      put(body_f(14'h0000, 1'b0));
      check("p4_mid_valid", 64'(valid_out), 64'(0));
      put(body_f(14'h1555, 1'b0));
      put(body_f(14'h2AAA, 1'b1));
      full = {10'h3FF, 14'h0000, 14'h1555, 14'h2AAA};
      check("p4_valid", 64'(valid_out), 64'(1));
      check("p4_vc",    64'(vc_out),    64'(1));
      check("p4_len",   64'(len_out),   64'(4));
      check("p4_data",  64'(data_out),  64'(full[51:4]));
      tick();
      check("p4_drain", 64'(valid_out), 64'(0));
      check("p4_noerr", 64'(err_cnt - e0), 64'(0));

      // back-to-back single-flit packets
      put(head_f(1'b0, 10'h001, 1'b1));
      check("s1_valid", 64'(valid_out), 64'(1));
      check("s1_data",  64'(data_out),  64'({10'h001, 38'h0}));
      check("s1_len",   64'(len_out),   64'(1));
      put(head_f(1'b0, 10'h002, 1'b1));
      check("s2_valid", 64'(valid_out), 64'(1));
      check("s2_data",  64'(data_out),  64'({10'h002, 38'h0}));
      check("s2_len",   64'(len_out),   64'(1));
      tick();
      check("s2_drain", 64'(valid_out), 64'(0));

      // backpressure: first word held while a second packet waits
      word_a   = {10'h155, 14'h0123, 24'h0};
      word_b   = {10'h2AA, 14'h3FFF, 24'h0};
      ready_in = 1'b0;
      put(head_f(1'b1, 10'h155, 1'b0));
      put(body_f(14'h0123, 1'b1));
      check("bp_valid", 64'(valid_out), 64'(1));
      check("bp_vc",    64'(vc_out),    64'(1));
      check("bp_len",   64'(len_out),   64'(2));
      out_q.delete();
      fork
         begin
            put(head_f(1'b0, 10'h2AA, 1'b0));
            put(body_f(14'h3FFF, 1'b1));
         end
         begin
            repeat (5) begin
               check("bp_stall_ready", 64'(ready_out), 64'(0));
               check("bp_stall_data",  64'(data_out),  64'(word_a));
               tick();
            end
            ready_in = 1'b1;
         end
      join
      repeat (3) tick();
      check("bp_count", 64'(out_q.size()), 64'(2));
      if (out_q.size() >= 2) begin
         check("bp_a_data", 64'(out_q[0].d), 64'(word_a));
         check("bp_a_len",  64'(out_q[0].l), 64'(2));
         check("bp_b_data", 64'(out_q[1].d), 64'(word_b));
         check("bp_b_vc",   64'(out_q[1].v), 64'(0));
         check("bp_b_len",  64'(out_q[1].l), 64'(2));
      end

      // orphan body, then abandoned packet followed by head+tail
      e0 = err_cnt;
      out_q.delete();
      put(body_f(14'h1111, 1'b1));
      check("orph_err",   64'(err_out),   64'(1));
      check("orph_valid", 64'(valid_out), 64'(0));
      put(head_f(1'b1, 10'h0AA, 1'b0));
      put(body_f(14'h0BBB, 1'b0));
      put(head_f(1'b0, 10'h0CC, 1'b1));
      check("abn_err",   64'(err_out),   64'(1));
      check("abn_valid", 64'(valid_out), 64'(1));
      check("abn_len",   64'(len_out),   64'(1));
      check("abn_vc",    64'(vc_out),    64'(0));
      check("abn_data",  64'(data_out),  64'({10'h0CC, 38'h0}));
      tick();
      check("abn_err_clr", 64'(err_out), 64'(0));
      tick();
      check("abn_err_cnt", 64'(err_cnt - e0), 64'(2));
      check("abn_outputs", 64'(out_q.size()), 64'(1));

      // missing tail: forced completion at MAX_FLITS, then orphan
      e0 = err_cnt;
      put(head_f(1'b1, 10'h001, 1'b0));
      put(body_f(14'h0001, 1'b0));
      put(body_f(14'h0002, 1'b0));
      put(body_f(14'h0003, 1'b0));
      full = {10'h001, 14'h0001, 14'h0002, 14'h0003};
      check("max_valid", 64'(valid_out), 64'(1));
      check("max_len",   64'(len_out),   64'(4));
      check("max_err",   64'(err_out),   64'(1));
      check("max_data",  64'(data_out),  64'(full[51:4]));
      put(body_f(14'h0004, 1'b0));
      check("max_orph_err",   64'(err_out),   64'(1));
      check("max_orph_valid", 64'(valid_out), 64'(0));
      tick();
      check("max_err_cnt", 64'(err_cnt - e0), 64'(2));

      // reset mid-packet
      put(head_f(1'b1, 10'h3C3, 1'b0));
      put(body_f(14'h1234, 1'b0));
      rst_n = 1'b0;
      #1;
      check("mrst_valid", 64'(valid_out), 64'(0));
      check("mrst_data",  64'(data_out),  64'(0));
      check("mrst_len",   64'(len_out),   64'(0));
      check("mrst_vc",    64'(vc_out),    64'(0));
      tick();
      rst_n = 1'b1;
      tick();
      e0 = err_cnt;
      put(head_f(1'b0, 10'h0F0, 1'b0));
      put(body_f(14'h2222, 1'b1));
      check("post_valid", 64'(valid_out), 64'(1));
      check("post_len",   64'(len_out),   64'(2));
      check("post_vc",    64'(vc_out),    64'(0));
      check("post_data",  64'(data_out),  64'({10'h0F0, 14'h2222, 24'h0}));
      tick();
      check("post_noerr", 64'(err_cnt - e0), 64'(0));

      tick();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/depacketizer_n.md
# depacketizer_n

Multi-flit, flit-serial depacketizer. It accepts one NoC flit per cycle over a valid/ready handshake and strips the per-flit control, VC and destination fields. It reassembles the payload of a packet of 1..MAX_FLITS flits into one data word, which it presents, with VC and length, from a one-entry output register. It sits between a NoC fabric port and a module's streaming input. It is the sequential, variable-length generalisation of the two-flit combinational depacketizer.

## Interface
- WIDTH_FLIT, 18, bits per flit.
- MAX_FLITS, 4, maximum flits per packet; must be ≥ 1.
- WIDTH_DATA, 48, output data width; must be ≤ CAP.
- VC_ADDRESS_WIDTH, 1, VC field width.
- ADDRESS_WIDTH, 4, destination field width; present in the head flit only.
- Derived HP = WIDTH_FLIT-3-VC_ADDRESS_WIDTH-ADDRESS_WIDTH (head payload bits).
- Derived BP = WIDTH_FLIT-3-VC_ADDRESS_WIDTH (body payload bits).
- Derived CAP = HP + (MAX_FLITS-1)*BP.
- Derived LW = clog2(MAX_FLITS+1).
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flit_in  in  WIDTH_FLIT  incoming flit.
- valid_in  in  1  flit_in valid.
- ready_out  out  1  block can accept a flit this cycle.
- data_out  out  WIDTH_DATA  reassembled payload.
- vc_out  out  VC_ADDRESS_WIDTH  VC taken from the head flit.
- len_out  out  LW  number of flits in the packet.
- valid_out  out  1  output register holds a packet.
- ready_in  in  1  downstream accepts the packet.
- err_out  out  1  one-cycle protocol-error pulse.

## Operation
- Flit fields, MSB first:
  - fv at bit F-1, hd at F-2, tl at F-3.
  - VC field follows.
  - Head flit only: dest field follows the VC.
  - Remainder is payload: HP bits for a head flit, BP bits otherwise.
  - dest is discarded.
- A flit is accepted when valid_in && ready_out.
- An accepted flit with fv=0 is consumed with no effect.
- Assembly vector asm[CAP-1:0]:
  - Cleared when a head flit is accepted.
  - Head payload occupies the top HP bits.
  - Body flit k (k=1..MAX_FLITS-1) occupies the next BP bits below flit k-1.
  - Slots not filled by a short packet remain 0.
  - data_out = top WIDTH_DATA bits of asm as it stands at completion.
- FSM has two states, IDLE and BODY, plus a flit counter cnt (LW bits).
- IDLE:
  - hd=1, tl=1: single-flit packet; complete with len 1; stay in IDLE.
  - hd=1, tl=0: latch VC, store payload, set cnt=1, go to BODY.
  - hd=0: orphan flit; drop it, pulse err_out, stay in IDLE.
- BODY:
  - hd=0: append payload and increment cnt.
  - If tl=1, or the new cnt equals MAX_FLITS, complete and return to IDLE.
  - Completion forced by MAX_FLITS with tl=0 also pulses err_out.
  - hd=1: abandon the partial packet with no output and pulse err_out. The flit is then processed as a head from IDLE in the same cycle.
- Completion loads data_out, vc_out, len_out and sets valid_out.
- valid_out clears when ready_in is high and no new completion occurs in that cycle.
- ready_out = !valid_out || ready_in. This is a combinational path from ready_in.
- err_out is registered, high for exactly one cycle per error event, and independent of valid_out.

## Timing
- Reset state:
  - ready_out=1, valid_out=0, err_out=0.
  - data_out, vc_out and len_out are 0.
  - FSM is in IDLE, cnt=0, asm=0.
- Reset mid-packet discards the partial packet and any held output.
- Latency: the completing flit is accepted in cycle t; valid_out=1 with data at t+1.
- Throughput: one flit per cycle. With ready_in=1, back-to-back single-flit packets produce one output per cycle.
- Completion in the same cycle that ready_in drains the old word: the new word replaces it and valid_out stays 1.
- Output held (valid_out && !ready_in): ready_out=0 and all input is stalled, so no flit is lost. data_out, vc_out and len_out are stable until the handshake.
- An error and a completion in the same cycle (forced MAX_FLITS end) are both visible at t+1.

## Test plan
Defaults: F=18, V=1, A=4, MAX=4, W=48, so HP=10 and BP=14.
- 4-flit packet, VC=1, head payload 10'h3FF, bodies 14'h0000 and 14'h1555, tail 14'h2AAA -> one cycle after the tail: valid_out=1, vc_out=1, len_out=4, data_out = top 48 bits of {10'h3FF, 14'h0, 14'h1555, 14'h2AAA}; err_out stays 0.
- Head+tail flit with payload 10'h001, followed immediately by another with 10'h002, ready_in=1 -> consecutive outputs {10'h001, 38'h0} and {10'h002, 38'h0}, each with len_out=1.
- Packet completes with ready_in=0, then a second packet is offered -> ready_out=0 and flits are held. Raise ready_in after 5 cycles -> first word is delivered unchanged, second follows intact; no dropped flits.
- Body flit in IDLE -> err_out pulses once and valid_out stays 0. Then head, body, then a new head+tail -> err_out pulses and only the head+tail packet is output, with len_out=1.
- 5 flits with no tail (head plus 4 bodies) -> output after the 4th flit with len_out=4 and an err_out pulse; the 5th flit is an orphan, giving a second err_out pulse.
- rst_n low for 1 cycle after 2 flits of a 3-flit packet -> all outputs 0. A subsequent clean 2-flit packet outputs len_out=2 with correct data.
